// File: rtl/dpm_ecc_scrubber.sv
// Background ECC scrubber for one port of a dual-port ECC memory.
// Walks every address, reads the stored Hamming codeword and decodes it.
// Single-bit errors are corrected and written back. Uncorrectable syndromes
// are only counted. The memory port is shared with host traffic through a
// request/grant handshake.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_start          pulse, begins a pass from address 0 (ignored while busy)
//   i_continuous     restart from address 0 after each pass
//   i_grant          port granted to the scrubber this cycle
//   o_req            scrubber wants the memory port
//   o_mem_en/we      memory port enable / write enable (only with grant)
//   o_mem_addr       memory address
//   o_mem_din        corrected codeword during write-back, else 0
//   i_mem_dout       codeword read from memory, READ_LATENCY after accept
//   o_busy, o_done   pass in progress / one-cycle end-of-pass pulse
//   o_corr_count     corrected single-bit errors, saturating
//   o_uncorr_count   uncorrectable words seen, saturating
//
// state   | meaning
// IDLE    | waiting for i_start
// RD_REQ  | requesting the port for a read of the current address
// RD_WAIT | read accepted, waiting out the memory latency
// CHECK   | decode captured word, update counters
// WR_REQ  | requesting the port to write back the corrected word
// NEXT    | advance address or finish the pass
module dpm_ecc_scrubber #(
  parameter int WIDTH        = 8,
  parameter int CODE_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 5,
  parameter int READ_LATENCY = 5,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_continuous,
  input  logic                  i_grant,
  output logic                  o_req,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [CODE_WIDTH-1:0] o_mem_din,
  input  logic [CODE_WIDTH-1:0] i_mem_dout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_corr_count,
  output logic [CNT_WIDTH-1:0]  o_uncorr_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  // One syndrome bit per parity bit.
  localparam int SYN_W = CODE_WIDTH - WIDTH;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LAT_W-1:0]      lat_cnt;
  logic [CODE_WIDTH-1:0] rd_word;
  logic [CODE_WIDTH-1:0] fix_word;
  logic [SYN_W-1:0]      syn;
  logic [CODE_WIDTH-1:0] flip_mask;
  logic                  correctable;

  // Syndrome is the XOR of the (1-based) positions of all set bits; a
  // correctable syndrome names the position of the flipped bit directly.
  always_comb begin
    syn       = '0;
    flip_mask = '0;
    for (int k = 0; k < CODE_WIDTH; k++) begin
      if (rd_word[k]) syn = syn ^ SYN_W'(k + 1);
    end
    for (int k = 0; k < CODE_WIDTH; k++) begin
      flip_mask[k] = (syn == SYN_W'(k + 1));
    end
    correctable = (syn != '0) && (syn <= SYN_W'(CODE_WIDTH));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      addr           <= '0;
      lat_cnt        <= '0;
      rd_word        <= '0;
      fix_word       <= '0;
      o_corr_count   <= '0;
      o_uncorr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            o_corr_count   <= '0;
            o_uncorr_count <= '0;
            addr           <= '0;
            state          <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (i_grant) begin
            lat_cnt <= LAT_W'(READ_LATENCY - 1);
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Capture lands exactly READ_LATENCY edges after the accepting edge.
          if (lat_cnt == '0) begin
            rd_word <= i_mem_dout;
            state   <= CHECK;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        CHECK: begin
          fix_word <= rd_word ^ flip_mask;
          if (correctable) begin
            if (o_corr_count != '1) o_corr_count <= o_corr_count + CNT_WIDTH'(1);
            state <= WR_REQ;
          end else begin
            if (syn != '0 && o_uncorr_count != '1)
              o_uncorr_count <= o_uncorr_count + CNT_WIDTH'(1);
            state <= NEXT;
          end
        end
        WR_REQ: begin
          if (i_grant) state <= NEXT;
        end
        NEXT: begin
          if (addr != ADDR_WIDTH'(DEPTH - 1)) begin
            addr  <= addr + ADDR_WIDTH'(1);
            state <= RD_REQ;
          end else begin
            addr  <= '0;
            state <= i_continuous ? RD_REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port strobes follow grant combinationally so a grant is used the same
  // cycle; the state register dropping on reset kills any pending write.
  assign o_req      = (state == RD_REQ) || (state == WR_REQ);
  assign o_mem_en   = o_req && i_grant;
  assign o_mem_we   = (state == WR_REQ) && i_grant;
  assign o_mem_addr = addr;
  assign o_mem_din  = o_mem_we ? fix_word : '0;
  assign o_busy     = (state != IDLE);
  assign o_done     = (state == NEXT) && (addr == ADDR_WIDTH'(DEPTH - 1));

endmodule

// File: doc/dpm_ecc_scrubber.md
Name: dpm_ecc_scrubber

Overview:
Background ECC scrubber that drives one port of the dual-port ECC memory, upstream of the memory array. It walks every address, reads the stored 12-bit Hamming codeword, and decodes it. Single-bit errors are corrected and written back; uncorrectable syndromes are counted only. It yields the port to host traffic through a request/grant handshake.

Parameters:
WIDTH, 8, data bits per word
CODE_WIDTH, 12, stored codeword bits (Hamming SEC over WIDTH)
ADDR_WIDTH, 5, memory address bits
DEPTH, 2**ADDR_WIDTH, words scanned per pass
READ_LATENCY, 5, clocks from accepted read request to valid i_mem_dout
CNT_WIDTH, 8, width of error counters

Ports:
i_clk  input  1  single clock; all state changes on its rising edge
i_rst  input  1  asynchronous active-high reset
i_start  input  1  pulse; begins a scrub pass from address 0
i_continuous  input  1  1 = restart from address 0 after each pass
i_grant  input  1  port granted to scrubber this cycle
o_req  output  1  scrubber wants the memory port
o_mem_en  output  1  memory port enable
o_mem_we  output  1  memory port write enable
o_mem_addr  output  ADDR_WIDTH  memory address
o_mem_din  output  CODE_WIDTH  corrected codeword for write-back
i_mem_dout  input  CODE_WIDTH  codeword read from memory
o_busy  output  1  pass in progress
o_done  output  1  one-cycle pulse at end of each pass
o_corr_count  output  CNT_WIDTH  single-bit errors corrected, saturating
o_uncorr_count  output  CNT_WIDTH  uncorrectable words seen, saturating

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; address 0; counters 0. No partial write may be issued, because o_mem_en drops with reset.
- Code layout: codeword bit k holds Hamming position k+1. Parity bits are at positions 1, 2, 4, 8. Data d0..d7 are at positions 3, 5, 6, 7, 9, 10, 11, 12. Even parity.
- Syndrome S (4 bits) is the XOR of the position indices of all set bits.
  - S=0: clean.
  - S in 1..12: flip bit S-1 and count as corrected.
  - S in 13..15: uncorrectable; no write-back.
- FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT.
- IDLE: if i_start=1, clear both counters, set address to 0, go to RD_REQ. o_busy is 1 in every state except IDLE.
- RD_REQ: o_req=1.
  - o_mem_en=1 and o_mem_we=0 only while i_grant=1.
  - The cycle with i_grant=1 accepts the read; then go to RD_WAIT.
  - While i_grant=0, hold with o_mem_en=0.
- RD_WAIT: o_req=0. Count READ_LATENCY-1 clocks, then capture i_mem_dout on the edge exactly READ_LATENCY clocks after the accepting edge, and go to CHECK.
- CHECK (1 cycle): compute the syndrome and update the counters. Counters saturate at 2^CNT_WIDTH-1 and never wrap. S in 1..12 goes to WR_REQ; otherwise go to NEXT.
- WR_REQ: o_req=1. While i_grant=1, drive o_mem_en=1, o_mem_we=1, o_mem_din = corrected word, o_mem_addr = current address; then go to NEXT. While i_grant=0, hold.
- NEXT:
  - If address < DEPTH-1: increment it and go to RD_REQ.
  - Else: pulse o_done for 1 cycle and wrap the address to 0. Go to RD_REQ if i_continuous=1, else go to IDLE.
  - Counters are not cleared between continuous passes.
- i_start is ignored while o_busy=1.
- o_mem_en=0 in every state other than RD_REQ/WR_REQ with grant. o_mem_din is 0 when not writing.
- Minimum per-word time with grant always high:
  - clean word: 1 + READ_LATENCY + 1 + 1 clocks;
  - corrected word: one additional clock.

Test Plan:
- Reset mid-pass at address 7 during WR_REQ -> o_mem_en falls asynchronously; all outputs 0; no write observed; a later i_start restarts at address 0.
- All 32 words hold valid codewords for 0x00..0x1F, i_grant=1 -> o_done pulses once after 32×8=256 clocks; both counters 0; no write-back cycles.
- Word 3 = codeword(0xA5) with bit 6 (position 7) flipped -> S=7; a write to address 3 of codeword(0xA5); o_corr_count=1.
- Word 10 with syndrome 14 (two-bit error) -> no write to address 10; o_uncorr_count=1; the pass completes normally.
- i_grant held low for 20 cycles in RD_REQ at address 5 -> o_req=1 and o_mem_en=0 throughout; the read is issued on the first grant cycle; data is captured exactly 5 clocks later.
- i_continuous=1, 300 corrected words injected -> o_corr_count saturates at 255; the address wraps 31→0; o_done pulses each pass.
